// File: rtl/data_mem_responder.sv
// Load/store responder for the RV32I data port. It takes one request, waits WAIT_CYCLES, then does a byte/half/word access.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned half/word accesses. Without it, those accesses are force-aligned.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int AW    = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic            q_we;
    logic [2:0]      q_funct3;
    logic [AW-1:0]   q_addr;
    logic [31:0]     q_wdata;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            access;
    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]      lane;
    logic            legal;
    logic            misal;
    logic            err;
    logic [3:0]      be;
    logic [31:0]     wword;
    logic [31:0]     rword;
    logic [31:0]     shifted;
    logic [31:0]     ldata;
    logic            ext_bit;

    // Address bits above the memory's byte range alias and are dropped.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:AW];

    assign accept = (state == S_IDLE) && req_valid;
    // cnt holds the remaining wait cycles; the access edge is the WAIT edge where it reaches zero.
    assign access = (state == S_WAIT) && (cnt == 4'd0);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid)     state_nxt = S_WAIT;
            S_WAIT:  if (cnt == 4'd0)   state_nxt = S_RESP;
            S_RESP:  if (rsp_ready)     state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= 4'd0;
            q_we     <= 1'b0;
            q_funct3 <= 3'd0;
            q_addr   <= '0;
            q_wdata  <= 32'd0;
        end else if (accept) begin
            cnt      <= 4'(WAIT_CYCLES);
            q_we     <= req_we;
            q_funct3 <= req_funct3;
            q_addr   <= req_addr[AW-1:0];
            q_wdata  <= req_wdata;
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign widx  = q_addr[AW-1:2];
    assign rword = mem[widx];

    always_comb begin
        lane  = q_addr[1:0];
        legal = q_we ? (q_funct3 <= 3'b010)
                     : (q_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal = ((q_funct3[1:0] == 2'b01) && q_addr[0]) ||
                ((q_funct3[1:0] == 2'b10) && (q_addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_ERR_EN
        err = !legal || misal;
`else
        err = !legal;
        if (q_funct3[1:0] == 2'b01) lane[0] = 1'b0;
        if (q_funct3[1:0] == 2'b10) lane    = 2'b00;
`endif
        be      = 4'b0000;
        wword   = q_wdata;
        shifted = rword >> {lane, 3'b000};
        ext_bit = 1'b0;
        ldata   = rword;
        case (q_funct3[1:0])
            2'b00: begin
                be      = 4'b0001 << lane;
                wword   = {4{q_wdata[7:0]}};
                ext_bit = !q_funct3[2] && shifted[7];
                ldata   = {{24{ext_bit}}, shifted[7:0]};
            end
            2'b01: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wword   = {2{q_wdata[15:0]}};
                ext_bit = !q_funct3[2] && shifted[15];
                ldata   = {{16{ext_bit}}, shifted[15:0]};
            end
            default: begin
                be      = 4'b1111;
                wword   = q_wdata;
                ldata   = rword;
            end
        endcase
    end

    // NOTE: the memory array has no reset; only the control and response registers are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && access && q_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (access) begin
            rsp_err   <= err;
            rsp_rdata <= (q_we || err) ? 32'd0 : ldata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. It covers latency, load extension, byte/half stores, backpressure, illegal funct3 and reset mid-request.
module tb_data_mem_responder;

    localparam int WAIT = 2;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        for (int n = 0; n < 40 && !req_ready; n++) begin
            @(posedge clk); #1;
        end
        if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(WAIT + 1));
    endtask

    task automatic take_rsp(input string tag, input logic [31:0] exp_d, input logic exp_e);
        check({tag, "_rdata"}, rsp_rdata, exp_d);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_d, input logic exp_e);
        send(we, f3, a, d);
        wait_rsp(tag);
        take_rsp(tag, exp_d, exp_e);
    endtask

    initial begin
        logic [31:0] held;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);

        // 1: word store/load
        do_req("sw10", 1'b1, F_W, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        do_req("lw10", 1'b0, F_W, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        do_req("lw_alias", 1'b0, F_W, 32'h1010, 32'd0, 32'hDEADBEEF, 1'b0);

        // 2: byte store and extension
        do_req("sw10_zero", 1'b1, F_W, 32'h10, 32'h0, 32'd0, 1'b0);
        do_req("sb13", 1'b1, F_B, 32'h13, 32'h80, 32'd0, 1'b0);
        do_req("lb13", 1'b0, F_B, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0);
        do_req("lbu13", 1'b0, F_BU, 32'h13, 32'd0, 32'h00000080, 1'b0);
        do_req("lw10_b", 1'b0, F_W, 32'h10, 32'd0, 32'h80000000, 1'b0);

        // 3: half loads
        do_req("sw10_c", 1'b1, F_W, 32'h10, 32'h80011234, 32'd0, 1'b0);
        do_req("lh12", 1'b0, F_H, 32'h12, 32'd0, 32'hFFFF8001, 1'b0);
        do_req("lhu12", 1'b0, F_HU, 32'h12, 32'd0, 32'h00008001, 1'b0);
        do_req("lh10", 1'b0, F_H, 32'h10, 32'd0, 32'h00001234, 1'b0);
        do_req("lb11", 1'b0, F_B, 32'h11, 32'd0, 32'h00000012, 1'b0);
        do_req("sh12", 1'b1, F_H, 32'h12, 32'h5555ABCD, 32'd0, 1'b0);
        do_req("lw10_sh", 1'b0, F_W, 32'h10, 32'd0, 32'hABCD1234, 1'b0);

        // 4: backpressure; a store offered during RESP must be ignored
        do_req("sw30_zero", 1'b1, F_W, 32'h30, 32'h0, 32'd0, 1'b0);
        send(1'b0, F_W, 32'h10, 32'd0);
        wait_rsp("bp");
        held = rsp_rdata;
        check("bp_first", held, 32'hABCD1234);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_W;
        req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid_hold", 32'(rsp_valid), 32'd1);
            check("bp_rdata_hold", rsp_rdata, 32'hABCD1234);
            check("bp_ready_low", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        take_rsp("bp", 32'hABCD1234, 1'b0);
        do_req("lw30", 1'b0, F_W, 32'h30, 32'd0, 32'h0, 1'b0);

        // 5: misalignment and illegal funct3
`ifdef DMEM_MISALIGN_ERR_EN
        do_req("lw11_mis", 1'b0, F_W, 32'h11, 32'd0, 32'h0, 1'b1);
        do_req("lhu13_mis", 1'b0, F_HU, 32'h13, 32'd0, 32'h0, 1'b1);
`else
        do_req("lw11_mis", 1'b0, F_W, 32'h11, 32'd0, 32'hABCD1234, 1'b0);
        do_req("lhu13_mis", 1'b0, F_HU, 32'h13, 32'd0, 32'h0000ABCD, 1'b0);
`endif
        do_req("ld_f011", 1'b0, 3'b011, 32'h10, 32'd0, 32'h0, 1'b1);
        do_req("st_f011", 1'b1, 3'b011, 32'h10, 32'h11111111, 32'h0, 1'b1);
        do_req("ld_f110", 1'b0, 3'b110, 32'h10, 32'd0, 32'h0, 1'b1);
        do_req("lw10_kept", 1'b0, F_W, 32'h10, 32'd0, 32'hABCD1234, 1'b0);

        // 6: reset during WAIT drops the store
        do_req("sw20_prior", 1'b1, F_W, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0);
        send(1'b1, F_W, 32'h20, 32'h12345678);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1 check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        do_req("lw20_prior", 1'b0, F_W, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
